spike_time_capture: RTL

SPIKE_TIME_CAPTURE -- requirements
Module: spike_time_capture

---
 rtl/spike_time_capture.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spike_time_capture.sv
`default_nettype none
// ============================================================================
// Module   : spike_time_capture
// Brief    : Latches the first-spike time of each channel within a fixed window.
// Revision : 1.0
// ============================================================================
module spike_time_capture #(
    parameter int NUM_CH = 4,
    parameter int TIME_W = 4,
    parameter int PERIOD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        spike_in,
    input  logic                     result_ready,
    output logic [TIME_W-1:0]        time_val,
    output logic                     busy,
    output logic                     result_valid,
    output logic [NUM_CH*TIME_W-1:0] spike_time,
    output logic [NUM_CH-1:0]        no_spike
);

    localparam logic [TIME_W-1:0] c_LAST = TIME_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIME_W-1:0]  r_time;
    logic [TIME_W-1:0]  w_time_nxt;
    logic               r_busy;
    logic               r_valid;
    logic [TIME_W-1:0]  r_st [NUM_CH];
    logic [NUM_CH-1:0]  r_ns;
    logic               w_clear;
    logic               w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_clear     = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_time_nxt = '0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                w_capture = 1'b1;
                if (r_time == c_LAST) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_time_nxt = r_time + 1'b1;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_time_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_time  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ns    <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_st[i] <= '1;
            end
        end else begin
            r_state <= w_state_nxt;
            r_time  <= w_time_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_valid <= (w_state_nxt == S_HOLD);
            if (w_clear) begin
                r_ns <= '1;
                for (int i = 0; i < NUM_CH; i++) begin
                    r_st[i] <= '1;
                end
            end else if (w_capture) begin
                // no_spike doubles as the "not yet latched" flag, so only the onset is kept
                for (int i = 0; i < NUM_CH; i++) begin
                    if (spike_in[i] && r_ns[i]) begin
                        r_st[i] <= r_time;
                        r_ns[i] <= 1'b0;
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
            assign spike_time[g*TIME_W +: TIME_W] = r_st[g];
        end
    endgenerate

    assign time_val     = r_time;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign no_spike     = r_ns;

endmodule
`default_nettype wire
